// File: rtl/adder_pkg.sv
// Shared types and helpers for the pipelined adder datapath.
package adder_pkg;

   typedef enum logic {
      ADD = 1'b0,
      SUB = 1'b1
   } op_e;

   // Control half of a pipeline stage; the data half is sized per instance.
   typedef struct packed {
      logic vld;
      logic carry;
   } stage_ctl_t;

   function automatic int slice_w(input int width, input int stages);
      return width / stages;
   endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational S-bit ripple slice built from full_adder cells.
module adder_slice #(
   parameter int S = 4
) (
   input  logic [S-1:0] i_a,
   input  logic [S-1:0] i_b,
   input  logic         i_c,
   output logic [S-1:0] o_sum,
   output logic         o_carry,
   output logic         o_ovf
);

   logic [S:0] w_c;

   assign w_c[0] = i_c;

   genvar i;
   generate
      for (i = 0; i < S; i++) begin : g_bit
         full_adder u_fa (
            .i_a (i_a[i]),
            .i_b (i_b[i]),
            .i_c (w_c[i]),
            .o_s (o_sum[i]),
            .o_c (w_c[i+1])
         );
      end
   endgenerate

   assign o_carry = w_c[S];
   // Only meaningful on the top slice, where these are the operand MSBs.
   assign o_ovf   = (i_a[S-1] == i_b[S-1]) && (o_sum[S-1] != i_a[S-1]);

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder cell; golden reference for the multi-bit adder.
module full_adder (
   input  logic i_a,
   input  logic i_b,
   input  logic i_c,
   output logic o_s,
   output logic o_c
);

   assign o_s = i_a ^ i_b ^ i_c;
   assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit add/sub: carry ripples through STAGES registered slices
// with valid/ready handshake and per-stage bubble collapsing.
module pipelined_adder
   import adder_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int S = slice_w(WIDTH, STAGES);
   localparam int L = STAGES - 1;

   op_e              w_op;
   logic [WIDTH-1:0] w_b_eff;
   logic             w_cin_eff;

   assign w_op      = op_e'(op);
   assign w_b_eff   = (w_op == SUB) ? ~b : b;
   assign w_cin_eff = (w_op == SUB) ? 1'b1 : cin;

   stage_ctl_t [L:0]            r_ctl;
   logic       [L:0][WIDTH-1:0] r_a;
   logic       [L:0][WIDTH-1:0] r_b;
   logic       [L:0][WIDTH-1:0] r_psum;
   logic                        r_ovf;

   logic [L:0]            w_load;
   logic [L:0]            w_src_vld;
   logic [L:0]            w_c_in;
   logic [L:0]            w_slice_c;
   logic [L:0]            w_slice_ovf;
   logic [L:0][S-1:0]     w_slice_sum;
   logic [L:0][WIDTH-1:0] w_a_src;
   logic [L:0][WIDTH-1:0] w_b_src;
   logic [L:0][WIDTH-1:0] w_psum_src;
   logic [L:0][WIDTH-1:0] w_psum_nxt;

   genvar k;
   generate
      for (k = 0; k < STAGES; k++) begin : g_stage
         if (k == 0) begin : g_head
            assign w_a_src[k]    = a;
            assign w_b_src[k]    = w_b_eff;
            assign w_psum_src[k] = '0;
            assign w_c_in[k]     = w_cin_eff;
            assign w_src_vld[k]  = in_valid;
         end else begin : g_body
            assign w_a_src[k]    = r_a[k-1];
            assign w_b_src[k]    = r_b[k-1];
            assign w_psum_src[k] = r_psum[k-1];
            assign w_c_in[k]     = r_ctl[k-1].carry;
            assign w_src_vld[k]  = r_ctl[k-1].vld;
         end

         // Load when empty or when the downstream stage moves this cycle.
         if (k == L) begin : g_tail_load
            assign w_load[k] = !r_ctl[k].vld || out_ready;
         end else begin : g_mid_load
            assign w_load[k] = !r_ctl[k].vld || w_load[k+1];
         end

         adder_slice #(.S(S)) u_slice (
            .i_a     (w_a_src[k][k*S +: S]),
            .i_b     (w_b_src[k][k*S +: S]),
            .i_c     (w_c_in[k]),
            .o_sum   (w_slice_sum[k]),
            .o_carry (w_slice_c[k]),
            .o_ovf   (w_slice_ovf[k])
         );

         // Bits above the slices done so far are always zero, so OR-in is safe.
         assign w_psum_nxt[k] = w_psum_src[k] | (WIDTH'(w_slice_sum[k]) << (k*S));
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ctl  <= '0;
         r_a    <= '0;
         r_b    <= '0;
         r_psum <= '0;
         r_ovf  <= 1'b0;
      end else begin
         for (int s = 0; s < STAGES; s++) begin
            if (w_load[s]) begin
               r_ctl[s].vld <= w_src_vld[s];
               if (w_src_vld[s]) begin
                  r_ctl[s].carry <= w_slice_c[s];
                  r_a[s]         <= w_a_src[s];
                  r_b[s]         <= w_b_src[s];
                  r_psum[s]      <= w_psum_nxt[s];
               end
            end
         end
         if (w_load[L] && w_src_vld[L])
            r_ovf <= w_slice_ovf[L];
      end
   end

   assign in_ready  = w_load[0];
   assign out_valid = r_ctl[L].vld;
   assign sum       = r_psum[L];
   assign cout      = r_ctl[L].carry;
   assign ovf       = r_ovf;

   // Last-stage operand copies and lower-slice ovf flags have no consumer.
   logic w_unused;
   assign w_unused = ^{r_a[L], r_b[L], w_slice_ovf};

endmodule
